inst_decode_pipe: RTL and testbench
===================================

Name: inst_decode_pipe

Overview:
Parametrised RV32I instruction decoder and successor of the current decode stage. It adds a valid/ready handshake, a configurable pipeline depth (1 or 2 register stages), full sign extension for every immediate format, illegal-instruction detection and a pipeline flush. It sits between the fetch unit and register-read/ALU issue, and emits the shared tDecodedInst record.

Parameters:
pStages, 2, register stages from iInst to oDecoded; legal values 1 or 2, anything else is an elaboration error.
pXlen, 32, immediate width; immediates are sign-extended to pXlen.

Ports:
iClk  in  1  clock; all logic on rising edge.
iRst  in  1  synchronous, active-high reset.
iFlush  in  1  discard all in-flight instructions.
iInst  in  32  raw instruction word.
iValid  in  1  iInst is valid.
oReady  out  1  decoder accepts iInst this cycle.
oDecoded  out  tDecodedInst  decoded fields: opcode, rs1/rs2/rd/funct3/funct7 each as {value,dv}, imm {value,dv}.
oIllegal  out  1  oDecoded is an illegal instruction; qualified by oValid.
oValid  out  1  oDecoded is valid.
iReady  in  1  downstream accepts oDecoded.

Behaviour:
- Reset: one iClk edge with iRst=1 forces oValid=0, oDecoded='0 and oIllegal=0, and clears every stage's valid bit. Reset takes priority over iFlush and over any handshake.
- Transfers:
  - Input transfer happens when iValid & oReady.
  - Output transfer happens when oValid & iReady.
  - iInst is sampled only on an input transfer.
- Stage advance: each stage register has a valid bit and loads when it is empty or its contents are leaving this cycle.
- oReady is combinational: oReady = !stage1.valid | stage1 advancing. With pStages=1 this reduces to oReady = !oValid | iReady.
- Latency and throughput: pStages cycles from input transfer to oValid. One instruction per cycle when iReady is held high, with no bubbles.
- Backpressure: when iReady=0 and oValid=1, oDecoded and oIllegal hold stable and nothing is dropped or duplicated. Order is strictly FIFO.
- Flush: iFlush=1 clears all valid bits on the next edge, so oValid=0 the following cycle. An instruction presented with iValid in the same cycle as iFlush is discarded. oReady remains as computed.
- Decode rules:
  - The opcode field is always copied.
  - rs1/rs2/rd/funct3/funct7 follow the per-opcode usage of the current decode stage, each written as {addr,1'b1}; fields an opcode does not use are '0.
- Immediates, always sign-extended from inst[31]:
  - I: inst[31:20]; used by LOAD, OP-IMM, JALR.
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
  - U: {inst[31:12],12'b0}; used by LUI, AUIPC.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
  - imm.dv=1 for every immediate format, including JALR.
- Illegal when any of the following holds:
  - inst[1:0] != 2'b11.
  - Unknown opcode.
  - LOAD with funct3 ∈ {011,110,111}.
  - STORE with funct3 >= 011.
  - BRANCH with funct3 ∈ {010,011}.
  - JALR with funct3 != 000.
  - OP with funct7 ∉ {0000000,0100000}, or funct7=0100000 with funct3 ∉ {000,101}.
  - OP-IMM with funct3=001 and funct7 != 0000000, or funct3=101 and funct7 ∉ {0000000,0100000}.
- Illegal output: oIllegal=1, all field dv bits=0, imm='0, opcode still copied. The instruction flows through the handshake like any other.
- FENCE and SYSTEM are legal; only the opcode is copied and all other fields are zero.
- pStages=2 split: stage 1 registers the raw word plus a pre-decoded opcode class; stage 2 performs immediate generation, the illegal check and the field write.

Decomposition:
- corePckg holds: tDecodedInst (unchanged), tOpcodeEnum extended with eOpSystem=7'b1110011, new tImmFmt enum {eImmNone,eImmI,eImmS,eImmB,eImmU,eImmJ}, and the funct3/funct7 legality constants.
- One natural sub-module, imm_gen: combinational, inputs inst[31:7] and tImmFmt, output pXlen-bit signed immediate. It is reusable by the branch-target unit.

Test Plan:
- Latency: ADDI x1,x2,-1 (0xFFF10093) with iReady=1 -> after 2 cycles oValid=1, rd={1,1}, rs1={2,1}, funct3={0,1}, imm.value=0xFFFFFFFF, imm.dv=1, oIllegal=0.
- B/J immediates: BEQ x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC. JAL x1,+2048 (0x001000EF) -> imm=0x00000800, rd={1,1}.
- Backpressure: stream 5 back-to-back SWs with iReady low for cycles 3-6 -> oReady drops, oDecoded held stable, all 5 emerge in order, no duplicates.
- Illegal: 0x00000000 and SUB-encoded AND (0x4020F0B3) -> oValid=1, oIllegal=1, dv bits 0. A following legal ADD decodes normally.
- Flush: 2 instructions in flight, iFlush pulse in the same cycle as a third iValid -> oValid=0 next cycle, none of the 3 emerge, the next instruction has normal latency.
- Reset: iRst asserted mid-stream with iReady=0 -> next cycle oValid=0 and oDecoded='0. Repeat with pStages=1 and check latency is 1.

Source files
------------

// File: rtl/inst_decode_pipe_pkg.sv
// Shared types for the RV32I decode stage: the decoded record, opcode and
// immediate-format enums, the pre-decoded opcode class and funct legality constants.
package inst_decode_pipe_pkg;

    localparam int cXlen = 32;

    typedef enum logic [6:0] {
        eOpLoad   = 7'b0000011,
        eOpFence  = 7'b0001111,
        eOpImm    = 7'b0010011,
        eOpAuipc  = 7'b0010111,
        eOpStore  = 7'b0100011,
        eOpOp     = 7'b0110011,
        eOpLui    = 7'b0110111,
        eOpBranch = 7'b1100011,
        eOpJalr   = 7'b1100111,
        eOpJal    = 7'b1101111,
        eOpSystem = 7'b1110011
    } tOpcodeEnum;

    typedef enum logic [2:0] {eImmNone, eImmI, eImmS, eImmB, eImmU, eImmJ} tImmFmt;

    typedef enum logic [3:0] {
        eClsBad, eClsLui, eClsAuipc, eClsJal, eClsJalr, eClsBranch,
        eClsLoad, eClsStore, eClsOpImm, eClsOp, eClsFence, eClsSystem
    } tOpClass;

    typedef struct packed { logic [4:0] value; logic dv; } tRegField;
    typedef struct packed { logic [2:0] value; logic dv; } tF3Field;
    typedef struct packed { logic [6:0] value; logic dv; } tF7Field;
    typedef struct packed { logic [cXlen-1:0] value; logic dv; } tImmField;

    typedef struct packed {
        logic [6:0] opcode;
        tRegField   rs1;
        tRegField   rs2;
        tRegField   rd;
        tF3Field    funct3;
        tF7Field    funct7;
        tImmField   imm;
    } tDecodedInst;

    localparam logic [2:0] cF3Add  = 3'b000;
    localparam logic [2:0] cF3Sll  = 3'b001;
    localparam logic [2:0] cF3Sr   = 3'b101;
    localparam logic [6:0] cF7Zero = 7'b0000000;
    localparam logic [6:0] cF7Alt  = 7'b0100000;

    // Opcodes carry inst[1:0]=2'b11, so a bad quadrant also lands in eClsBad.
    function automatic tOpClass classify(input logic [6:0] opcode);
        case (opcode)
            eOpLui:    return eClsLui;
            eOpAuipc:  return eClsAuipc;
            eOpJal:    return eClsJal;
            eOpJalr:   return eClsJalr;
            eOpBranch: return eClsBranch;
            eOpLoad:   return eClsLoad;
            eOpStore:  return eClsStore;
            eOpImm:    return eClsOpImm;
            eOpOp:     return eClsOp;
            eOpFence:  return eClsFence;
            eOpSystem: return eClsSystem;
            default:   return eClsBad;
        endcase
    endfunction

endpackage

// File: rtl/inst_decode_pipe_imm_gen.sv
// Combinational RV32I immediate generator; every format is sign-extended from
// inst[31] to pXlen bits. Also used by the branch-target unit.
module inst_decode_pipe_imm_gen
    import inst_decode_pipe_pkg::*;
#(
    parameter int pXlen = 32
) (
    input  logic [31:7]      inst,
    input  tImmFmt           fmt,
    output logic [pXlen-1:0] imm
);

    logic [31:0] raw;

    always_comb begin
        raw = '0;
        case (fmt)
            eImmI: raw = {{20{inst[31]}}, inst[31:20]};
            eImmS: raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            eImmB: raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            eImmU: raw = {inst[31:12], 12'b0};
            eImmJ: raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: raw = '0;
        endcase
    end

    assign imm = pXlen'($signed(raw));

endmodule

// File: rtl/inst_decode_pipe.sv
// RV32I decode stage with valid/ready handshake, 1 or 2 register stages,
// illegal-instruction detection and flush.
module inst_decode_pipe
    import inst_decode_pipe_pkg::*;
#(
    parameter int pStages = 2,
    parameter int pXlen   = 32
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iFlush,
    input  logic [31:0] iInst,
    input  logic        iValid,
    output logic        oReady,
    output tDecodedInst oDecoded,
    output logic        oIllegal,
    output logic        oValid,
    input  logic        iReady
);

    if (pStages != 1 && pStages != 2) begin : g_bad_stages
        $error("inst_decode_pipe: pStages must be 1 or 2");
    end
    if (pXlen != cXlen) begin : g_bad_xlen
        $error("inst_decode_pipe: pXlen must match the tDecodedInst immediate width");
    end

    logic        out_valid_reg;
    tDecodedInst out_dec_reg;
    logic        out_ill_reg;
    logic        out_load;

    logic        dec_valid;
    logic [31:0] dec_inst;
    tOpClass     dec_cls;

    assign out_load = !out_valid_reg || iReady;

    if (pStages == 1) begin : g_one
        assign oReady    = out_load;
        assign dec_valid = iValid;
        assign dec_inst  = iInst;
        assign dec_cls   = classify(iInst[6:0]);
    end else begin : g_two
        logic        s1_valid_reg;
        logic [31:0] s1_inst_reg;
        tOpClass     s1_cls_reg;
        logic        s1_load;

        // A full stage 1 can only reload when its word moves to the output stage.
        assign s1_load = !s1_valid_reg || out_load;

        always_ff @(posedge iClk) begin
            if (iRst) begin
                s1_valid_reg <= 1'b0;
                s1_inst_reg  <= '0;
                s1_cls_reg   <= eClsBad;
            end else if (iFlush) begin
                s1_valid_reg <= 1'b0;
            end else if (s1_load) begin
                s1_valid_reg <= iValid;
                if (iValid) begin
                    s1_inst_reg <= iInst;
                    s1_cls_reg  <= classify(iInst[6:0]);
                end
            end
        end

        assign oReady    = s1_load;
        assign dec_valid = s1_valid_reg;
        assign dec_inst  = s1_inst_reg;
        assign dec_cls   = s1_cls_reg;
    end

    logic             use_rd, use_rs1, use_rs2, use_f3, use_f7;
    logic             ill_next;
    tImmFmt           imm_fmt;
    logic [pXlen-1:0] imm_val;
    tDecodedInst      dec_next;
    logic [2:0]       f3;
    logic [6:0]       f7;

    assign f3 = dec_inst[14:12];
    assign f7 = dec_inst[31:25];

    inst_decode_pipe_imm_gen #(.pXlen(pXlen)) u_imm_gen (
        .inst (dec_inst[31:7]),
        .fmt  (imm_fmt),
        .imm  (imm_val)
    );

    always_comb begin
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_f3   = 1'b0;
        use_f7   = 1'b0;
        imm_fmt  = eImmNone;
        ill_next = 1'b0;
        case (dec_cls)
            eClsLui, eClsAuipc: begin
                use_rd  = 1'b1;
                imm_fmt = eImmU;
            end
            eClsJal: begin
                use_rd  = 1'b1;
                imm_fmt = eImmJ;
            end
            eClsJalr: begin
                {use_rd, use_rs1, use_f3} = 3'b111;
                imm_fmt  = eImmI;
                ill_next = (f3 != cF3Add);
            end
            eClsBranch: begin
                {use_rs1, use_rs2, use_f3} = 3'b111;
                imm_fmt  = eImmB;
                ill_next = (f3 == 3'b010) || (f3 == 3'b011);
            end
            eClsLoad: begin
                {use_rd, use_rs1, use_f3} = 3'b111;
                imm_fmt  = eImmI;
                ill_next = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            eClsStore: begin
                {use_rs1, use_rs2, use_f3} = 3'b111;
                imm_fmt  = eImmS;
                ill_next = (f3 >= 3'b011);
            end
            eClsOpImm: begin
                {use_rd, use_rs1, use_f3} = 3'b111;
                imm_fmt = eImmI;
                // Shifts reuse imm[11:5] as funct7.
                if (f3 == cF3Sll) begin
                    use_f7   = 1'b1;
                    ill_next = (f7 != cF7Zero);
                end else if (f3 == cF3Sr) begin
                    use_f7   = 1'b1;
                    ill_next = (f7 != cF7Zero) && (f7 != cF7Alt);
                end
            end
            eClsOp: begin
                {use_rd, use_rs1, use_rs2, use_f3, use_f7} = 5'b11111;
                ill_next = ((f7 != cF7Zero) && (f7 != cF7Alt)) ||
                           ((f7 == cF7Alt) && (f3 != cF3Add) && (f3 != cF3Sr));
            end
            eClsFence, eClsSystem: ill_next = 1'b0;
            default: ill_next = 1'b1;
        endcase
    end

    always_comb begin
        dec_next        = '0;
        dec_next.opcode = dec_inst[6:0];
        if (!ill_next) begin
            if (use_rd)  dec_next.rd     = '{value: dec_inst[11:7],  dv: 1'b1};
            if (use_rs1) dec_next.rs1    = '{value: dec_inst[19:15], dv: 1'b1};
            if (use_rs2) dec_next.rs2    = '{value: dec_inst[24:20], dv: 1'b1};
            if (use_f3)  dec_next.funct3 = '{value: f3, dv: 1'b1};
            if (use_f7)  dec_next.funct7 = '{value: f7, dv: 1'b1};
            if (imm_fmt != eImmNone) dec_next.imm = '{value: cXlen'(imm_val), dv: 1'b1};
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            out_valid_reg <= 1'b0;
            out_dec_reg   <= '0;
            out_ill_reg   <= 1'b0;
        end else if (iFlush) begin
            out_valid_reg <= 1'b0;
        end else if (out_load) begin
            out_valid_reg <= dec_valid;
            if (dec_valid) begin
                out_dec_reg <= dec_next;
                out_ill_reg <= ill_next;
            end
        end
    end

    assign oValid   = out_valid_reg;
    assign oDecoded = out_dec_reg;
    assign oIllegal = out_ill_reg;

endmodule

// File: tb/tb_inst_decode_pipe.sv
// Directed bench for inst_decode_pipe: two-stage instance for latency, decode,
// backpressure, illegal, flush and reset; single-stage instance for latency 1.
module tb_inst_decode_pipe;
    import inst_decode_pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, valid, rdy_in, ready, ovalid, ill;
    logic [31:0] inst;
    tDecodedInst dec;

    logic        flush1, valid1, rdy_in1, ready1, ovalid1, ill1;
    logic [31:0] inst1;
    tDecodedInst dec1;

    int checks = 0;
    int errors = 0;

    inst_decode_pipe #(.pStages(2), .pXlen(32)) dut (
        .iClk(clk), .iRst(rst), .iFlush(flush), .iInst(inst), .iValid(valid),
        .oReady(ready), .oDecoded(dec), .oIllegal(ill), .oValid(ovalid), .iReady(rdy_in)
    );

    inst_decode_pipe #(.pStages(1), .pXlen(32)) dut1 (
        .iClk(clk), .iRst(rst), .iFlush(flush1), .iInst(inst1), .iValid(valid1),
        .oReady(ready1), .oDecoded(dec1), .oIllegal(ill1), .oValid(ovalid1), .iReady(rdy_in1)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("pass %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_sw(input logic [4:0] rs2, input logic [4:0] off);
        return {7'b0, rs2, 5'd2, 3'b010, off, 7'b0100011};
    endfunction

    tDecodedInst exp_dec, held;
    logic [31:0] sw [5];
    int          sent, recv;
    bit          saw_block, have_hold;

    initial begin
        rst = 1'b1; flush = 1'b0; valid = 1'b0; rdy_in = 1'b1; inst = '0;
        flush1 = 1'b0; valid1 = 1'b0; rdy_in1 = 1'b1; inst1 = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", 128'(ovalid), 128'(0));
        check("rst_dec", 128'(dec), 128'(0));
        check("rst_ill", 128'(ill), 128'(0));
        check("rst_ready", 128'(ready), 128'(1));
        check("rst_valid1", 128'(ovalid1), 128'(0));

        // ADDI x1,x2,-1: two-cycle latency
        inst = 32'hFFF10093; valid = 1'b1;
        tick();
        valid = 1'b0;
        check("addi_lat1", 128'(ovalid), 128'(0));
        tick();
        check("addi_lat2", 128'(ovalid), 128'(1));
        check("addi_rd", 128'(dec.rd), 128'({5'd1, 1'b1}));
        check("addi_rs1", 128'(dec.rs1), 128'({5'd2, 1'b1}));
        check("addi_rs2", 128'(dec.rs2), 128'(0));
        check("addi_f3", 128'(dec.funct3), 128'({3'd0, 1'b1}));
        check("addi_imm", 128'(dec.imm), 128'({32'hFFFFFFFF, 1'b1}));
        check("addi_ill", 128'(ill), 128'(0));
        tick();
        check("addi_drain", 128'(ovalid), 128'(0));

        // BEQ x0,x0,-4 then JAL x1,+2048 back to back
        inst = 32'hFE000EE3; valid = 1'b1;
        tick();
        inst = 32'h001000EF;
        tick();
        check("beq_valid", 128'(ovalid), 128'(1));
        check("beq_imm", 128'(dec.imm), 128'({32'hFFFFFFFC, 1'b1}));
        check("beq_rs2", 128'(dec.rs2), 128'({5'd0, 1'b1}));
        check("beq_rd", 128'(dec.rd), 128'(0));
        valid = 1'b0;
        tick();
        check("jal_valid", 128'(ovalid), 128'(1));
        check("jal_imm", 128'(dec.imm), 128'({32'h00000800, 1'b1}));
        check("jal_rd", 128'(dec.rd), 128'({5'd1, 1'b1}));
        tick();

        // Illegal 0x0, SUB-encoded AND, then legal ADD x3,x1,x2
        inst = 32'h00000000; valid = 1'b1;
        tick();
        inst = 32'h4020F0B3;
        tick();
        check("ill0_valid", 128'(ovalid), 128'(1));
        check("ill0_ill", 128'(ill), 128'(1));
        check("ill0_dec", 128'(dec), 128'(0));
        inst = 32'h002081B3;
        tick();
        exp_dec = '0;
        exp_dec.opcode = 7'h33;
        check("illand_ill", 128'(ill), 128'(1));
        check("illand_dec", 128'(dec), 128'(exp_dec));
        valid = 1'b0;
        tick();
        check("add_valid", 128'(ovalid), 128'(1));
        check("add_ill", 128'(ill), 128'(0));
        check("add_rd", 128'(dec.rd), 128'({5'd3, 1'b1}));
        check("add_rs2", 128'(dec.rs2), 128'({5'd2, 1'b1}));
        check("add_f7", 128'(dec.funct7), 128'({7'd0, 1'b1}));
        check("add_imm", 128'(dec.imm), 128'(0));
        tick();

        // Backpressure: 5 SWs, iReady low in cycles 3..6
        for (int i = 0; i < 5; i++) sw[i] = mk_sw(5'(i + 3), 5'(4 * i));
        sent = 0; recv = 0; saw_block = 1'b0; have_hold = 1'b0;
        for (int c = 0; c < 40 && recv < 5; c++) begin
            rdy_in = !(c >= 3 && c <= 6);
            valid  = (sent < 5);
            inst   = (sent < 5) ? sw[sent] : 32'h0;
            #1;
            if (ovalid && !rdy_in) begin
                if (have_hold) check("bp_hold", 128'(dec), 128'(held));
                held = dec;
                have_hold = 1'b1;
                if (!ready) saw_block = 1'b1;
            end else begin
                have_hold = 1'b0;
            end
            if (ovalid && rdy_in) begin
                check("bp_rs2", 128'(dec.rs2), 128'({5'(recv + 3), 1'b1}));
                check("bp_imm", 128'(dec.imm), 128'({32'(4 * recv), 1'b1}));
                check("bp_f3", 128'(dec.funct3), 128'({3'b010, 1'b1}));
                recv++;
            end
            if (valid && ready) sent++;
            tick();
        end
        valid = 1'b0; rdy_in = 1'b1;
        check("bp_sent", 128'(sent), 128'(5));
        check("bp_recv", 128'(recv), 128'(5));
        check("bp_blocked", 128'(saw_block), 128'(1));
        check("bp_nodup", 128'(ovalid), 128'(0));
        tick();

        // Flush with two in flight and a third presented
        rdy_in = 1'b0;
        inst = 32'hFFF10093; valid = 1'b1;
        tick();
        inst = 32'hFE000EE3;
        tick();
        inst = 32'h001000EF; flush = 1'b1;
        tick();
        flush = 1'b0; valid = 1'b0;
        check("fl_valid", 128'(ovalid), 128'(0));
        rdy_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("fl_none", 128'(ovalid), 128'(0));
        end
        inst = 32'h123452B7; valid = 1'b1;
        tick();
        valid = 1'b0;
        check("fl_lui_lat1", 128'(ovalid), 128'(0));
        tick();
        check("fl_lui_lat2", 128'(ovalid), 128'(1));
        check("fl_lui_imm", 128'(dec.imm), 128'({32'h12345000, 1'b1}));
        check("fl_lui_rd", 128'(dec.rd), 128'({5'd5, 1'b1}));
        tick();

        // Reset mid-stream under backpressure
        rdy_in = 1'b0;
        inst = 32'hFFF10093; valid = 1'b1;
        tick();
        inst = 32'hFE000EE3;
        tick();
        check("mr_pre_valid", 128'(ovalid), 128'(1));
        inst = 32'h001000EF; rst = 1'b1;
        tick();
        rst = 1'b0; valid = 1'b0;
        check("mr_valid", 128'(ovalid), 128'(0));
        check("mr_dec", 128'(dec), 128'(0));
        check("mr_ill", 128'(ill), 128'(0));
        check("mr_ready", 128'(ready), 128'(1));
        rdy_in = 1'b1;
        tick();
        check("mr_s1_clear", 128'(ovalid), 128'(0));
        tick();
        check("mr_s1_clear2", 128'(ovalid), 128'(0));

        // Single-stage instance: latency 1 and ready = !oValid | iReady
        rdy_in1 = 1'b0;
        inst1 = 32'h001000EF; valid1 = 1'b1;
        #1;
        check("s1_ready_empty", 128'(ready1), 128'(1));
        tick();
        valid1 = 1'b0;
        check("s1_lat", 128'(ovalid1), 128'(1));
        check("s1_jal_imm", 128'(dec1.imm), 128'({32'h00000800, 1'b1}));
        check("s1_jal_rd", 128'(dec1.rd), 128'({5'd1, 1'b1}));
        #1;
        check("s1_ready_stall", 128'(ready1), 128'(0));
        rdy_in1 = 1'b1;
        #1;
        check("s1_ready_go", 128'(ready1), 128'(1));
        inst1 = 32'h40109093; valid1 = 1'b1;
        tick();
        exp_dec = '0;
        exp_dec.opcode = 7'h13;
        check("s1_slli_ill", 128'(ill1), 128'(1));
        check("s1_slli_dec", 128'(dec1), 128'(exp_dec));
        inst1 = 32'h4010D093;
        tick();
        check("s1_srai_ill", 128'(ill1), 128'(0));
        check("s1_srai_f7", 128'(dec1.funct7), 128'({7'b0100000, 1'b1}));
        check("s1_srai_imm", 128'(dec1.imm), 128'({32'h00000401, 1'b1}));
        inst1 = 32'h00013083;
        tick();
        check("s1_ld_ill", 128'(ill1), 128'(1));
        valid1 = 1'b0;
        tick();
        check("s1_drain", 128'(ovalid1), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
